// File: rtl/writeback_regfile.sv
// Writeback stage register feeding a 32x32 register file. Each write is committed one edge
// after it is captured, and reads bypass the pending stage entry.
module writeback_regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_valid,
   input  logic        wb_regWrite,
   input  logic        wb_memToReg,
   input  logic [4:0]  wb_writeRegister,
   input  logic [31:0] wb_aluResult,
   input  logic [31:0] wb_memData,
   input  logic [4:0]  rd_index1,
   input  logic [4:0]  rd_index2,
   output logic [31:0] rd_value1,
   output logic [31:0] rd_value2,
   output logic [31:0] retire_count,
   output logic        pending
);

   logic        stage_valid_q;
   logic [4:0]  stage_idx_q;
   logic [31:0] stage_data_q;
   logic        stage_valid_d;
   logic [31:0] stage_data_d;
   logic [31:0] regs_q [32];
   logic [31:0] retire_q;

   always_comb begin
      stage_valid_d = wb_valid & wb_regWrite & (wb_writeRegister != 5'd0);
      stage_data_d  = wb_memToReg ? wb_memData : wb_aluResult;
   end

   // When wb_valid is low, the index and data are held; only the valid bit matters.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_valid_q <= 1'b0;
         stage_idx_q   <= 5'd0;
         stage_data_q  <= 32'd0;
      end else begin
         stage_valid_q <= stage_valid_d;
         if (wb_valid) begin
            stage_idx_q  <= wb_writeRegister;
            stage_data_q <= stage_data_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= 32'd0;
         end
         retire_q <= 32'd0;
      end else if (stage_valid_q) begin
         regs_q[stage_idx_q] <= stage_data_q;
         retire_q            <= retire_q + 32'd1;
      end
   end

   always_comb begin
      rd_value1 = regs_q[rd_index1];
      if (rd_index1 == 5'd0) begin
         rd_value1 = 32'd0;
      end else if (stage_valid_q && (stage_idx_q == rd_index1)) begin
         rd_value1 = stage_data_q;
      end
   end

   always_comb begin
      rd_value2 = regs_q[rd_index2];
      if (rd_index2 == 5'd0) begin
         rd_value2 = 32'd0;
      end else if (stage_valid_q && (stage_idx_q == rd_index2)) begin
         rd_value2 = stage_data_q;
      end
   end

   assign retire_count = retire_q;
   assign pending      = stage_valid_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed scenarios plus random traffic compared every cycle
// against a queue-based model of pending writes.
module tb_writeback_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid, wb_regWrite, wb_memToReg;
   logic [4:0]  wb_writeRegister;
   logic [31:0] wb_aluResult, wb_memData;
   logic [4:0]  rd_index1, rd_index2;
   logic [31:0] rd_value1, rd_value2, retire_count;
   logic        pending;

   int total = 0;
   int passed = 0;
   bit chk_en = 1'b0;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
   } wr_t;

   wr_t         m_q[$];
   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;

   always #5 clk = ~clk;

   writeback_regfile dut (
      .clk              (clk),
      .reset            (reset),
      .wb_valid         (wb_valid),
      .wb_regWrite      (wb_regWrite),
      .wb_memToReg      (wb_memToReg),
      .wb_writeRegister (wb_writeRegister),
      .wb_aluResult     (wb_aluResult),
      .wb_memData       (wb_memData),
      .rd_index1        (rd_index1),
      .rd_index2        (rd_index2),
      .rd_value1        (rd_value1),
      .rd_value2        (rd_value2),
      .retire_count     (retire_count),
      .pending          (pending)
   );

   // Model: a write becomes architectural one edge after it is accepted.
   always @(posedge clk) begin
      if (reset) begin
         m_q.delete();
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_cnt = 32'd0;
      end else begin
         if (m_q.size() > 0) begin
            m_regs[m_q[0].idx] = m_q[0].data;
            m_cnt = m_cnt + 32'd1;
            void'(m_q.pop_front());
         end
         if (wb_valid && wb_regWrite && wb_writeRegister != 5'd0)
            m_q.push_back('{idx: wb_writeRegister,
                            data: wb_memToReg ? wb_memData : wb_aluResult});
      end
   end

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      for (int i = m_q.size() - 1; i >= 0; i--)
         if (m_q[i].idx == idx) return m_q[i].data;
      return m_regs[idx];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_rd1", rd_value1, m_read(rd_index1));
         check("model_rd2", rd_value2, m_read(rd_index2));
         check("model_retire", retire_count, m_cnt);
         check("model_pending", {31'd0, pending}, {31'd0, m_q.size() != 0});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input logic rw, input logic m2r, input logic [4:0] idx,
                          input logic [31:0] alu, input logic [31:0] mem);
      wb_valid = 1'b1;
      wb_regWrite = rw;
      wb_memToReg = m2r;
      wb_writeRegister = idx;
      wb_aluResult = alu;
      wb_memData = mem;
   endtask

   task automatic idle();
      wb_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      wb_valid = 1'b0; wb_regWrite = 1'b0; wb_memToReg = 1'b0;
      wb_writeRegister = 5'd0; wb_aluResult = 32'd0; wb_memData = 32'd0;
      rd_index1 = 5'd0; rd_index2 = 5'd0;
      cyc(); cyc();
      chk_en = 1'b1;
      reset = 1'b0;
      rd_index1 = 5'd5; rd_index2 = 5'd31;
      #1;
      check("reset_rd1", rd_value1, 32'd0);
      check("reset_rd2", rd_value2, 32'd0);
      check("reset_retire", retire_count, 32'd0);
      check("reset_pending", {31'd0, pending}, 32'd0);

      // Basic write
      set_req(1'b1, 1'b0, 5'd5, 32'h12345678, 32'h0);
      cyc(); idle(); #1;
      check("basic_pending1", {31'd0, pending}, 32'd1);
      check("basic_bypass", rd_value1, 32'h12345678);
      cyc(); #1;
      check("basic_pending0", {31'd0, pending}, 32'd0);
      check("basic_file", rd_value1, 32'h12345678);
      check("basic_retire", retire_count, 32'd1);

      // Write to r0 is dropped
      set_req(1'b1, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF);
      rd_index1 = 5'd0;
      cyc(); idle(); #1;
      check("r0_pending", {31'd0, pending}, 32'd0);
      check("r0_read", rd_value1, 32'd0);
      cyc(); #1;
      check("r0_retire", retire_count, 32'd1);

      // Same-index collision, load select first
      set_req(1'b1, 1'b1, 5'd7, 32'h00001111, 32'hAAAA0001);
      rd_index1 = 5'd7;
      cyc(); #1;
      check("coll_bypass1", rd_value1, 32'hAAAA0001);
      set_req(1'b1, 1'b0, 5'd7, 32'hBBBB0002, 32'h00002222);
      cyc(); idle(); #1;
      check("coll_bypass2", rd_value1, 32'hBBBB0002);
      cyc(); cyc(); #1;
      check("coll_file", rd_value1, 32'hBBBB0002);
      check("coll_retire", retire_count, 32'd3);

      // Dual read with regWrite=0
      set_req(1'b1, 1'b0, 5'd3, 32'h3, 32'h0);
      cyc();
      set_req(1'b1, 1'b0, 5'd4, 32'h4, 32'h0);
      cyc(); idle(); cyc();
      set_req(1'b0, 1'b0, 5'd3, 32'h77, 32'h77);
      rd_index1 = 5'd3; rd_index2 = 5'd4;
      cyc(); idle(); #1;
      check("dual_pending", {31'd0, pending}, 32'd0);
      check("dual_rd1", rd_value1, 32'h3);
      check("dual_rd2", rd_value2, 32'h4);
      cyc(); #1;
      check("dual_retire", retire_count, 32'd5);

      // Reset with an entry pending
      set_req(1'b1, 1'b0, 5'd9, 32'h99, 32'h0);
      rd_index1 = 5'd9;
      cyc(); idle(); reset = 1'b1;
      cyc(); reset = 1'b0; #1;
      check("rst_rd9", rd_value1, 32'd0);
      check("rst_pending", {31'd0, pending}, 32'd0);
      check("rst_retire", retire_count, 32'd0);
      check("rst_rd4", rd_value2, 32'd0);
      cyc(); #1;
      check("rst_rd9_later", rd_value1, 32'd0);

      // Counter wrap
      force dut.retire_q = 32'hFFFFFFFF;
      m_cnt = 32'hFFFFFFFF;
      #1 release dut.retire_q;
      set_req(1'b1, 1'b0, 5'd10, 32'hA, 32'h0);
      cyc(); idle(); #1;
      check("wrap_before", retire_count, 32'hFFFFFFFF);
      cyc(); #1;
      check("wrap_after", retire_count, 32'd0);

      // Random traffic, small index range to force collisions and bypass hits
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 59) == 0);
         wb_valid = ($urandom_range(0, 3) != 0);
         wb_regWrite = ($urandom_range(0, 4) != 0);
         wb_memToReg = $urandom_range(0, 1);
         wb_writeRegister = 5'($urandom_range(0, 9));
         if ($urandom_range(0, 7) == 0) wb_writeRegister = 5'($urandom_range(0, 31));
         wb_aluResult = $urandom;
         wb_memData = $urandom;
         rd_index1 = 5'($urandom_range(0, 9));
         rd_index2 = 5'($urandom_range(0, 31));
         cyc();
      end
      reset = 1'b0;
      idle();
      cyc(); cyc();
      chk_en = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
